// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32 subset main control FSM with memory timeout, trap and counters
module multicycle_control #(
  parameter int OP_W        = 7,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OP_W-1:0]  Op_i,
  input  logic             Zero_i,
  input  logic             MemReady_i,
  output logic             IMemReq_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             PCSrc_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             MemtoReg_o,
  output logic             RegWrite_o,
  output logic             Trap_o,
  output logic [2:0]       State_o,
  output logic [CNT_W-1:0] Cycles_o,
  output logic [CNT_W-1:0] Retired_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [OP_W-1:0] OP_R      = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_I      = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);

  // wait counter only needs to reach MEM_TIMEOUT-1; with the timeout disabled it just wraps unused
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cycles_q;
  logic [CNT_W-1:0]  retired_q;
  logic              trap_q;
  logic              retire;
  logic              wait_hit;
  logic              op_legal;

  assign op_legal = (Op_i == OP_R) || (Op_i == OP_I) || (Op_i == OP_LOAD) ||
                    (Op_i == OP_STORE) || (Op_i == OP_BRANCH);
  assign wait_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // next-state selection; ready beats the timeout when both land in the same cycle
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (MemReady_i)    state_d = S_DECODE;
        else if (wait_hit) state_d = S_TRAP;
      end
      S_DECODE: state_d = op_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (op_q == OP_BRANCH) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (op_q == OP_R || op_q == OP_I) begin
          state_d = S_WB;
        end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        if (MemReady_i) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // state, latched opcode, wait counter, sticky trap and performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      cycles_q  <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_q + CNT_W'(1);
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (state_d == S_TRAP) trap_q <= 1'b1;
      if (state_q == S_DECODE) op_q <= Op_i;
      if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q)
        wait_q <= '0;
      else if ((state_q == S_FETCH || state_q == S_MEM) && !MemReady_i)
        wait_q <= wait_q + WAIT_W'(1);
    end
  end

  // control outputs decoded from the current state; everything is held low during reset
  always_comb begin
    IMemReq_o  = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    PCSrc_o    = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = 2'b00;
    ALUOp_o    = 2'b00;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    MemtoReg_o = 1'b0;
    RegWrite_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          IMemReq_o = 1'b1;
          ALUSrcB_o = 2'b01;
          IRWrite_o = MemReady_i;
          PCWrite_o = MemReady_i;
        end
        S_DECODE: ALUSrcB_o = 2'b10;
        S_EXEC: begin
          ALUSrcA_o = 1'b1;
          if (op_q == OP_R) begin
            ALUOp_o = 2'b10;
          end else if (op_q == OP_I) begin
            ALUSrcB_o = 2'b10;
            ALUOp_o   = 2'b11;
          end else if (op_q == OP_BRANCH) begin
            ALUOp_o   = 2'b01;
            PCSrc_o   = 1'b1;
            PCWrite_o = Zero_i;
          end else begin
            ALUSrcB_o = 2'b10;
          end
        end
        S_MEM: begin
          MemRead_o  = (op_q == OP_LOAD);
          MemWrite_o = (op_q == OP_STORE);
        end
        S_WB: begin
          RegWrite_o = 1'b1;
          MemtoReg_o = (op_q == OP_LOAD);
        end
        default: ;
      endcase
    end
  end

  assign Trap_o    = trap_q;
  assign State_o   = state_q;
  assign Cycles_o  = cycles_q;
  assign Retired_o = retired_q;

endmodule
